// File: rtl/amba3_axi_pkg.sv
// Shared AXI3 slave definitions: burst/response encodings, default sizes,
// FSM state types and the illegal-burst rule used by both channels.
package amba3_axi_pkg;

  localparam int unsigned DEF_TXID_SIZE = 4;
  localparam int unsigned DEF_ADDR_SIZE = 32;
  localparam int unsigned DEF_DATA_SIZE = 128;
  localparam int unsigned DEF_MEM_WORDS = 256;

  localparam logic [1:0] FIXED  = 2'b00;
  localparam logic [1:0] INCR   = 2'b01;
  localparam logic [1:0] WRAP   = 2'b10;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

  // Reserved burst type, or a WRAP whose beat count is not 2/4/8/16.
  function automatic logic burst_illegal(input logic [1:0] burst, input logic [3:0] len);
    return (burst == 2'b11) ||
           ((burst == WRAP) && !((len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15)));
  endfunction

endpackage

// File: rtl/amba3_axi_addr_gen.sv
// Next-beat address for FIXED/INCR/WRAP bursts; sizes wider than the bus
// are clamped to the bus width.
module amba3_axi_addr_gen import amba3_axi_pkg::*; #(
  parameter int unsigned ADDR_SIZE = DEF_ADDR_SIZE,
  parameter int unsigned DATA_SIZE = DEF_DATA_SIZE
) (
  input  logic [ADDR_SIZE-1:0] addr,
  input  logic [2:0]           size,
  input  logic [3:0]           len,
  input  logic [1:0]           burst,
  output logic [ADDR_SIZE-1:0] next_addr
);

  localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_SIZE / 8));

  logic [2:0]           eff_size;
  logic [ADDR_SIZE-1:0] nbytes;
  logic [ADDR_SIZE-1:0] aligned;
  logic [ADDR_SIZE-1:0] incr;
  logic [ADDR_SIZE-1:0] window;
  logic [ADDR_SIZE-1:0] wrapped;

  always_comb begin
    eff_size = (size > MAX_SIZE) ? MAX_SIZE : size;
    nbytes   = ADDR_SIZE'(1) << eff_size;
    aligned  = addr & ~(nbytes - ADDR_SIZE'(1));
    incr     = aligned + nbytes;
    window   = nbytes * ADDR_SIZE'({1'b0, len} + 5'd1);
    // Window is a power of two for legal WRAP lengths, so masking wraps it.
    wrapped  = (addr & ~(window - ADDR_SIZE'(1))) | (incr & (window - ADDR_SIZE'(1)));
    next_addr = incr;
    if (burst == FIXED) begin
      next_addr = addr;
    end else if ((burst == WRAP) && !burst_illegal(burst, len)) begin
      next_addr = wrapped;
    end
  end

endmodule

// File: rtl/amba3_axi_slave.sv
// AXI3 memory slave: independent write (AW/W/B) and read (AR/R) FSMs over a
// byte-enabled word memory; one outstanding burst per direction.
module amba3_axi_slave import amba3_axi_pkg::*; #(
  parameter int unsigned TXID_SIZE = DEF_TXID_SIZE,
  parameter int unsigned ADDR_SIZE = DEF_ADDR_SIZE,
  parameter int unsigned DATA_SIZE = DEF_DATA_SIZE,
  parameter int unsigned MEM_WORDS = DEF_MEM_WORDS
) (
  input  logic                   aclk,
  input  logic                   areset_n,
  input  logic [TXID_SIZE-1:0]   awid,
  input  logic [ADDR_SIZE-1:0]   awaddr,
  input  logic [3:0]             awlen,
  input  logic [2:0]             awsize,
  input  logic [1:0]             awburst,
  input  logic                   awvalid,
  output logic                   awready,
  input  logic [TXID_SIZE-1:0]   wid,
  input  logic [DATA_SIZE-1:0]   wdata,
  input  logic [DATA_SIZE/8-1:0] wstrb,
  input  logic                   wlast,
  input  logic                   wvalid,
  output logic                   wready,
  output logic [TXID_SIZE-1:0]   bid,
  output logic [1:0]             bresp,
  output logic                   bvalid,
  input  logic                   bready,
  input  logic [TXID_SIZE-1:0]   arid,
  input  logic [ADDR_SIZE-1:0]   araddr,
  input  logic [3:0]             arlen,
  input  logic [2:0]             arsize,
  input  logic [1:0]             arburst,
  input  logic                   arvalid,
  output logic                   arready,
  output logic [TXID_SIZE-1:0]   rid,
  output logic [DATA_SIZE-1:0]   rdata,
  output logic [1:0]             rresp,
  output logic                   rlast,
  output logic                   rvalid,
  input  logic                   rready
);

  localparam int unsigned STRB_W  = DATA_SIZE / 8;
  localparam int unsigned IDX_LSB = $clog2(STRB_W);
  localparam int unsigned IDX_W   = $clog2(MEM_WORDS);

  logic [DATA_SIZE-1:0] mem [MEM_WORDS];

  w_state_e w_state, w_state_nxt;
  r_state_e r_state, r_state_nxt;
  logic     live;

  logic [ADDR_SIZE-1:0] w_addr, w_addr_nxt, r_addr, r_addr_nxt;
  logic [3:0]           w_len, w_cnt, r_len, r_cnt;
  logic [2:0]           w_size, r_size;
  logic [1:0]           w_burst, r_burst;
  logic                 w_err, r_err;
  logic                 aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic                 unused_ok;

  assign unused_ok = ^wid;

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid  && wready;
  assign b_hs  = bvalid  && bready;
  assign ar_hs = arvalid && arready;
  assign r_hs  = rvalid  && rready;

  amba3_axi_addr_gen #(.ADDR_SIZE(ADDR_SIZE), .DATA_SIZE(DATA_SIZE)) u_waddr (
    .addr(w_addr), .size(w_size), .len(w_len), .burst(w_burst), .next_addr(w_addr_nxt)
  );

  amba3_axi_addr_gen #(.ADDR_SIZE(ADDR_SIZE), .DATA_SIZE(DATA_SIZE)) u_raddr (
    .addr(r_addr), .size(r_size), .len(r_len), .burst(r_burst), .next_addr(r_addr_nxt)
  );

  // live holds the ready outputs low until the first edge after reset release.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
      live    <= 1'b0;
    end else begin
      w_state <= w_state_nxt;
      r_state <= r_state_nxt;
      live    <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = w_state;
    unique case (w_state)
      W_IDLE: if (aw_hs) w_state_nxt = W_DATA;
      W_DATA: if (w_hs && (w_cnt == w_len)) w_state_nxt = W_RESP;
      W_RESP: if (b_hs) w_state_nxt = W_IDLE;
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_nxt = r_state;
    unique case (r_state)
      R_IDLE: if (ar_hs) r_state_nxt = R_DATA;
      R_DATA: if (r_hs && rlast) r_state_nxt = R_IDLE;
      default: r_state_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    awready = live && (w_state == W_IDLE);
    wready  = (w_state == W_DATA);
    bvalid  = (w_state == W_RESP);
    arready = live && (r_state == R_IDLE);
    rvalid  = (r_state == R_DATA);
    rlast   = rvalid && (r_cnt == r_len);
  end

  assign bresp = w_err ? SLVERR : OKAY;
  assign rresp = r_err ? SLVERR : OKAY;

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      w_addr  <= '0;
      w_len   <= '0;
      w_size  <= '0;
      w_burst <= '0;
      w_cnt   <= '0;
      w_err   <= 1'b0;
      bid     <= '0;
    end else if (aw_hs) begin
      w_addr  <= awaddr;
      w_len   <= awlen;
      w_size  <= awsize;
      w_burst <= awburst;
      w_cnt   <= '0;
      w_err   <= burst_illegal(awburst, awlen);
      bid     <= awid;
    end else if (w_hs) begin
      w_addr <= w_addr_nxt;
      w_cnt  <= w_cnt + 4'd1;
      if (wlast != (w_cnt == w_len)) w_err <= 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (w_hs) begin
      for (int unsigned b = 0; b < STRB_W; b++) begin
        if (wstrb[b]) mem[w_addr[IDX_LSB +: IDX_W]][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Reads sample mem before this edge's write lands, giving read-first order.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      r_addr  <= '0;
      r_len   <= '0;
      r_size  <= '0;
      r_burst <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      rid     <= '0;
      rdata   <= '0;
    end else if (ar_hs) begin
      r_addr  <= araddr;
      r_len   <= arlen;
      r_size  <= arsize;
      r_burst <= arburst;
      r_cnt   <= '0;
      r_err   <= burst_illegal(arburst, arlen);
      rid     <= arid;
      rdata   <= mem[araddr[IDX_LSB +: IDX_W]];
    end else if (r_hs && !rlast) begin
      r_addr <= r_addr_nxt;
      r_cnt  <= r_cnt + 4'd1;
      rdata  <= mem[r_addr_nxt[IDX_LSB +: IDX_W]];
    end
  end

endmodule

// File: tb/tb_amba3_axi_slave.sv
// Directed bench for amba3_axi_slave: narrow/wrap/fixed writes, stalled
// multi-burst traffic, read/write collision, illegal bursts and mid-burst reset.
module tb_amba3_axi_slave;
  import amba3_axi_pkg::*;

  logic         aclk = 1'b0;
  logic         areset_n = 1'b0;
  logic [3:0]   awid = '0, wid = '0, arid = '0, bid, rid;
  logic [31:0]  awaddr = '0, araddr = '0;
  logic [3:0]   awlen = '0, arlen = '0;
  logic [2:0]   awsize = '0, arsize = '0;
  logic [1:0]   awburst = '0, arburst = '0, bresp, rresp;
  logic         awvalid = 1'b0, wvalid = 1'b0, wlast = 1'b0, bready = 1'b0;
  logic         arvalid = 1'b0, rready = 1'b0;
  logic         awready, wready, bvalid, arready, rvalid, rlast;
  logic [127:0] wdata = '0, rdata;
  logic [15:0]  wstrb = '0;

  logic [127:0] wd [16];
  logic [15:0]  ws [16];
  logic [127:0] rd [16];
  int unsigned  checks = 0, passes = 0, fails = 0;

  amba3_axi_slave #(.TXID_SIZE(4), .ADDR_SIZE(32), .DATA_SIZE(128), .MEM_WORDS(256)) dut (
    .aclk(aclk), .areset_n(areset_n),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  always #5 aclk = ~aclk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] pat(input int unsigned id, input int unsigned beat);
    return {16{4'(id), 4'(beat)}};
  endfunction

  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input bit bad_last,
                          input int unsigned stall_max, input logic [1:0] exp_resp, input string tag);
    int unsigned n;
    int unsigned st;
    logic [5:0] snap;
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    n = 0;
    while (awready !== 1'b1 && n < 100) begin @(posedge aclk); #1; n++; end
    check({tag, "_awready"}, awready, 1'b1);
    @(posedge aclk); #1;
    awvalid = 1'b0;
    for (int unsigned b = 0; b <= 32'(len); b++) begin
      wdata = wd[b]; wstrb = ws[b]; wlast = (b == 32'(len)) ^ bad_last; wvalid = 1'b1;
      n = 0;
      while (wready !== 1'b1 && n < 100) begin @(posedge aclk); #1; n++; end
      @(posedge aclk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
    check({tag, "_bvalid"}, bvalid, 1'b1);
    snap = {bid, bresp};
    st = $urandom_range(stall_max, 0);
    repeat (st) begin
      @(posedge aclk); #1;
      check({tag, "_b_stable"}, {bvalid, bid, bresp}, {1'b1, snap});
    end
    check({tag, "_bid"}, bid, id);
    check({tag, "_bresp"}, bresp, exp_resp);
    bready = 1'b1;
    @(posedge aclk); #1;
    bready = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst,
                         input int unsigned stall_max, input logic [1:0] exp_resp, input string tag);
    int unsigned n;
    int unsigned st;
    logic [127:0] snap_d;
    logic [6:0]   snap_c;
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    n = 0;
    while (arready !== 1'b1 && n < 100) begin @(posedge aclk); #1; n++; end
    check({tag, "_arready"}, arready, 1'b1);
    @(posedge aclk); #1;
    arvalid = 1'b0;
    for (int unsigned b = 0; b <= 32'(len); b++) begin
      check({tag, "_rvalid"}, rvalid, 1'b1);
      snap_d = rdata; snap_c = {rid, rresp, rlast};
      st = $urandom_range(stall_max, 0);
      repeat (st) begin
        @(posedge aclk); #1;
        check({tag, "_rdata_stable"}, rdata, snap_d);
        check({tag, "_rctl_stable"}, {rvalid, rid, rresp, rlast}, {1'b1, snap_c});
      end
      check({tag, "_rid"}, rid, id);
      check({tag, "_rresp"}, rresp, exp_resp);
      check({tag, "_rlast"}, rlast, b == 32'(len));
      rd[b] = rdata;
      rready = 1'b1;
      @(posedge aclk); #1;
      rready = 1'b0;
    end
    check({tag, "_rvalid_end"}, rvalid, 1'b0);
  endtask

  initial begin
    logic [127:0] old_w, new_w;
    int unsigned m;

    // Reset state and ready rise after release.
    repeat (2) @(posedge aclk);
    #1;
    check("rst_ctl", {awready, wready, bvalid, arready, rvalid, rlast, bresp, rresp, bid, rid}, '0);
    check("rst_rdata", rdata, '0);
    areset_n = 1'b1;
    check("rel_awready_low", {awready, arready}, 2'b00);
    @(posedge aclk); #1;
    check("rel_ready_high", {awready, arready}, 2'b11);

    // Clear the words used by the narrow-transfer tests.
    wd[0] = '0; ws[0] = '1;
    do_write(4'd0, 32'h100, 4'd0, 3'd4, INCR, 1'b0, 0, OKAY, "clr100");
    do_write(4'd0, 32'h700, 4'd0, 3'd4, INCR, 1'b0, 0, OKAY, "clr700");

    // INCR size0, five byte beats.
    wd[0] = 128'h07; wd[1] = 128'h15 << 8; wd[2] = 128'h23 << 16; wd[3] = 128'h31 << 24; wd[4] = 128'h39 << 32;
    ws[0] = 16'h0001; ws[1] = 16'h0002; ws[2] = 16'h0004; ws[3] = 16'h0008; ws[4] = 16'h0010;
    do_write(4'd5, 32'h100, 4'd4, 3'd0, INCR, 1'b0, 0, OKAY, "incr_b");
    do_read(4'd6, 32'h100, 4'd0, 3'd4, INCR, 0, OKAY, "incr_r");
    check("incr_data", rd[0], 128'h0000_0039_3123_1507);

    // WRAP size2 len3 starting mid-window.
    wd[0] = 128'h2211 << 32; wd[1] = 128'h7766 << 64; wd[2] = 128'h5432 << 96; wd[3] = 128'h7123;
    ws[0] = 16'h00f0; ws[1] = 16'h0f00; ws[2] = 16'hf000; ws[3] = 16'h000f;
    do_write(4'd2, 32'h704, 4'd3, 3'd2, WRAP, 1'b0, 0, OKAY, "wrap_b");
    do_read(4'd3, 32'h700, 4'd0, 3'd4, INCR, 0, OKAY, "wrap_r");
    check("wrap_data", rd[0], 128'h0000_5432_0000_7766_0000_2211_0000_7123);

    // FIXED size0: every beat lands on byte 6 of the same word.
    wd[0] = 128'h07 << 48; wd[1] = 128'h15 << 48; wd[2] = 128'h23 << 48; wd[3] = 128'h31 << 48; wd[4] = 128'h39 << 48;
    for (int i = 0; i < 5; i++) ws[i] = 16'h0040;
    do_write(4'd1, 32'h106, 4'd4, 3'd0, FIXED, 1'b0, 0, OKAY, "fixed_b");
    do_read(4'd1, 32'h100, 4'd0, 3'd4, INCR, 0, OKAY, "fixed_r");
    check("fixed_byte6", rd[0][55:48], 8'h39);
    check("fixed_word", rd[0], 128'h0039_0039_3123_1507);

    // Illegal bursts and wlast mismatch: SLVERR, data still written.
    wd[0] = 128'hDEAD_BEEF; ws[0] = '1;
    do_write(4'd7, 32'h200, 4'd0, 3'd4, 2'b11, 1'b0, 0, SLVERR, "rsvd_b");
    do_read(4'd8, 32'h200, 4'd0, 3'd4, 2'b11, 0, SLVERR, "rsvd_r");
    check("rsvd_data", rd[0], 128'hDEAD_BEEF);
    wd[0] = pat(9, 0); wd[1] = pat(9, 1); wd[2] = pat(9, 2); ws[1] = '1; ws[2] = '1;
    do_write(4'd9, 32'h240, 4'd2, 3'd4, WRAP, 1'b0, 0, SLVERR, "wrap3_b");
    do_write(4'd10, 32'h280, 4'd1, 3'd4, INCR, 1'b1, 0, SLVERR, "wlast_b");
    do_read(4'd10, 32'h280, 4'd1, 3'd4, INCR, 0, OKAY, "wlast_r");
    check("wlast_data0", rd[0], pat(9, 0));
    check("wlast_data1", rd[1], pat(9, 1));

    // Same-word read and write on one edge returns the old word.
    old_w = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    new_w = 128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000;
    wd[0] = old_w; ws[0] = '1;
    do_write(4'd7, 32'h300, 4'd0, 3'd4, INCR, 1'b0, 0, OKAY, "rw_old");
    awid = 4'd9; awaddr = 32'h300; awlen = 4'd0; awsize = 3'd4; awburst = INCR; awvalid = 1'b1;
    check("rw_awready", awready, 1'b1);
    @(posedge aclk); #1;
    awvalid = 1'b0;
    wdata = new_w; wstrb = '1; wlast = 1'b1; wvalid = 1'b1;
    arid = 4'd10; araddr = 32'h300; arlen = 4'd0; arsize = 3'd4; arburst = INCR; arvalid = 1'b1;
    check("rw_both_ready", {wready, arready}, 2'b11);
    @(posedge aclk); #1;
    wvalid = 1'b0; wlast = 1'b0; arvalid = 1'b0;
    check("rw_valids", {bvalid, rvalid, rlast}, 3'b111);
    check("rw_read_first", rdata, old_w);
    rready = 1'b1; bready = 1'b1;
    @(posedge aclk); #1;
    rready = 1'b0; bready = 1'b0;
    do_read(4'd11, 32'h300, 4'd0, 3'd4, INCR, 0, OKAY, "rw_new");
    check("rw_new_data", rd[0], new_w);

    // Overlapping INCR bursts with random response stalls.
    for (int k = 1; k <= 4; k++) begin
      for (int j = 0; j < 4; j++) begin wd[j] = pat(k, j); ws[j] = '1; end
      do_write(4'(k), 32'(k * 16), 4'd3, 3'd4, INCR, 1'b0, 10, OKAY, "multi_b");
    end
    for (int k = 1; k <= 4; k++) begin
      do_read(4'(k), 32'(k * 16), 4'd3, 3'd4, INCR, 10, OKAY, "multi_r");
      for (int j = 0; j < 4; j++) begin
        m = (k + j < 4) ? 32'(k + j) : 32'd4;
        check("multi_data", rd[j], pat(m, 32'(k + j) - m));
      end
    end

    // Reset in the middle of a write burst.
    awid = 4'd3; awaddr = 32'h500; awlen = 4'd3; awsize = 3'd4; awburst = INCR; awvalid = 1'b1;
    check("mid_awready", awready, 1'b1);
    @(posedge aclk); #1;
    awvalid = 1'b0;
    for (int j = 0; j < 2; j++) begin
      wdata = pat(3, j); wstrb = '1; wlast = 1'b0; wvalid = 1'b1;
      check("mid_wready", wready, 1'b1);
      @(posedge aclk); #1;
    end
    wvalid = 1'b0;
    #2 areset_n = 1'b0;
    #1;
    check("mid_rst_ctl", {awready, wready, bvalid, arready, rvalid, rlast, bresp, bid}, '0);
    @(posedge aclk); #1;
    check("mid_rst_hold", {awready, wready, bvalid, arready, rvalid, rlast}, '0);
    areset_n = 1'b1;
    check("mid_rel_low", awready, 1'b0);
    @(posedge aclk); #1;
    check("mid_rel_high", {awready, arready}, 2'b11);
    wd[0] = pat(4, 0); ws[0] = '1;
    do_write(4'd4, 32'h520, 4'd0, 3'd4, INCR, 1'b0, 0, OKAY, "post_b");
    do_read(4'd5, 32'h500, 4'd2, 3'd4, INCR, 0, OKAY, "post_r");
    check("post_kept0", rd[0], pat(3, 0));
    check("post_kept1", rd[1], pat(3, 1));
    check("post_new", rd[2], pat(4, 0));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/amba3_axi_slave.md
AMBA3_AXI_SLAVE -- requirements
Module: amba3_axi_slave

Interface
REQ-001 TXID_SIZE, default 4, width of all ID fields.
REQ-002 ADDR_SIZE, default 32, byte-address width.
REQ-003 DATA_SIZE, default 128, data bus width; STRB width = DATA_SIZE/8.
REQ-004 MEM_WORDS, default 256, memory depth in DATA_SIZE words; word index = (addr / (DATA_SIZE/8)) mod MEM_WORDS.
REQ-005 aclk  in  1  single clock; all logic on rising edge.
REQ-006 areset_n  in  1  reset, asynchronous, active-low.
REQ-007 AW: awid[TXID] awaddr[ADDR] awlen[4] awsize[3] awburst[2] awvalid  in; awready  out.
REQ-008 W: wid[TXID] wdata[DATA] wstrb[STRB] wlast wvalid  in; wready  out.
REQ-009 B: bid[TXID] bresp[2] bvalid  out; bready  in.
REQ-010 AR: arid araddr arlen arsize arburst arvalid  in (widths as AW); arready  out.
REQ-011 R: rid[TXID] rdata[DATA] rresp[2] rlast rvalid  out; rready  in.

Function
REQ-012 Handshake: transfer occurs on a rising edge with valid&&ready high; outputs with valid high are held stable until accepted.
REQ-013 Write FSM W_IDLE/W_DATA/W_RESP: W_IDLE drives awready=1; AW handshake latches id/addr/len/size/burst and enters W_DATA.
REQ-014 W_DATA drives wready=1; each W handshake writes the wdata byte lanes with wstrb=1 into the current word, then advances the address.
REQ-015 On beat number awlen (0-based), enter W_RESP regardless of wlast; bvalid=1 and bid=latched awid on the following cycle.
REQ-016 bresp=OKAY (00), or SLVERR (10) if wlast mismatched the beat count, awburst=11, or WRAP len is not 1/3/7/15; the data is still written.
REQ-017 W_RESP: B handshake returns to W_IDLE; at most one write burst is outstanding.
REQ-018 Read FSM R_IDLE/R_DATA: R_IDLE drives arready=1; AR handshake latches the fields and enters R_DATA.
REQ-019 In R_DATA, rvalid=1 one cycle after the AR handshake; rdata is the full memory word, registered.
REQ-020 On each R handshake, load the next word in the same edge so back-to-back beats are possible; rid=arid; rlast=1 on beat arlen.
REQ-021 rresp=OKAY, or SLVERR on an illegal burst as in REQ-016; after the rlast handshake return to R_IDLE.
REQ-022 Address generation: FIXED (00) keeps the address. INCR (01) adds 2^size to the size-aligned address; the first beat uses the unaligned address.
REQ-023 WRAP (10): the address advances as INCR but wraps within an aligned window of (len+1)*2^size bytes.
REQ-024 The read and write channels operate concurrently. If both access the same word in one cycle, the read returns the old data (read-first).
REQ-025 wid, awsize beyond the bus width, and the upper address bits beyond the memory depth are ignored.

Reset
REQ-026 While areset_n=0: awready, wready, bvalid, arready, rvalid and rlast are 0; bresp, rresp, bid, rid and rdata are 0; both FSMs are in IDLE.
REQ-027 Reset mid-burst aborts the burst; beats already written remain. Memory contents are not cleared and are unknown after power-up.
REQ-028 awready and arready rise on the first rising edge after areset_n deasserts.

Structure
REQ-029 Package amba3_axi_pkg holds: burst constants FIXED/INCR/WRAP, response constants OKAY/SLVERR, default parameter values, and the FSM state enums.
REQ-030 One sub-module, amba3_axi_addr_gen (addr, size, len, burst -> next addr), is instantiated once each for the write path and the read path.

Verification
REQ-031 INCR size0 @0x100, five bytes 07,15,23,31,39, strb 0x0001..0x0010 -> bresp OKAY; read @0x100 len0 size4 -> rdata 0x0000_0039_3123_1507, rlast=1.
REQ-032 WRAP size2 len3 @0x704, data 2211, 7766, 5432, 7123, strb 0x00f0/0x0f00/0xf000/0x000f -> beats go to 0x704, 0x708, 0x70C, 0x700; read @0x700 -> rdata 0x0000_5432_0000_7766_0000_2211_0000_7123.
REQ-033 FIXED size0 @0x106, five beats strb 0x0040, bytes 07..39 -> byte 6 of word 0x100 = 0x39.
REQ-034 Four INCR len3 writes @0x10/0x20/0x30/0x40, ids 1-4, random 0-10-cycle bready/rready stalls, then reads of the same addresses -> bid/rid echo ids, data matches, and outputs stay stable while stalled.
REQ-035 Simultaneous read and write of one word -> old data returned; awburst=11 -> bresp SLVERR.
REQ-036 Reset asserted mid write burst -> all valid/ready outputs 0 within the reset; awready=1 one edge after release; the next write completes OKAY.
